// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source round-robin regfile writeback arbiter with 2-entry FIFOs
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   a_valid/a_wa/a_wd/a_ready ALU writeback request and handshake
//   l_valid/l_wa/l_wd/l_ready load-unit writeback request and handshake
//   rf_we/rf_wa/rf_wd         registered regfile write port
//   pend_mask                 one-hot OR of all accepted-but-unretired destinations
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_wa,
  input  logic [31:0] a_wd,
  output logic        a_ready,
  input  logic        l_valid,
  input  logic [4:0]  l_wa,
  input  logic [31:0] l_wd,
  output logic        l_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic [31:0] pend_mask
);
  logic [4:0]  a_wa_q [2];
  logic [4:0]  l_wa_q [2];
  logic [31:0] a_wd_q [2];
  logic [31:0] l_wd_q [2];
  logic        a_wp, a_rp, l_wp, l_rp, last_l;
  logic [1:0]  a_cnt, l_cnt;
  logic        a_push, l_push, a_pop, l_pop;
  assign a_ready = a_cnt != 2'd2;
  assign l_ready = l_cnt != 2'd2;
  // writes to x0 handshake normally but are dropped here
  assign a_push = a_valid & a_ready & (|a_wa);
  assign l_push = l_valid & l_ready & (|l_wa);
  // ALU wins when alone or when the load unit had the last grant
  assign a_pop = (a_cnt != 2'd0) & ((l_cnt == 2'd0) | last_l);
  assign l_pop = (l_cnt != 2'd0) & ~a_pop;
  always_ff @(posedge clk) begin
    if (a_push) begin
      a_wa_q[a_wp] <= a_wa;
      a_wd_q[a_wp] <= a_wd;
    end
    if (l_push) begin
      l_wa_q[l_wp] <= l_wa;
      l_wd_q[l_wp] <= l_wd;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_wp   <= 1'b0;
      a_rp   <= 1'b0;
      l_wp   <= 1'b0;
      l_rp   <= 1'b0;
      a_cnt  <= 2'd0;
      l_cnt  <= 2'd0;
      last_l <= 1'b1;
      rf_we  <= 1'b0;
      rf_wa  <= 5'd0;
      rf_wd  <= 32'd0;
    end else begin
      a_wp   <= a_wp ^ a_push;
      a_rp   <= a_rp ^ a_pop;
      l_wp   <= l_wp ^ l_push;
      l_rp   <= l_rp ^ l_pop;
      a_cnt  <= a_cnt + {1'b0, a_push} - {1'b0, a_pop};
      l_cnt  <= l_cnt + {1'b0, l_push} - {1'b0, l_pop};
      last_l <= (a_pop | l_pop) ? l_pop : last_l;
      rf_we  <= a_pop | l_pop;
      rf_wa  <= a_pop ? a_wa_q[a_rp] : l_pop ? l_wa_q[l_rp] : rf_wa;
      rf_wd  <= a_pop ? a_wd_q[a_rp] : l_pop ? l_wd_q[l_rp] : rf_wd;
    end
  end
  // a slot is live when the FIFO is full, or it is the head of a 1-entry FIFO
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < 2; i++) begin
      if (a_cnt == 2'd2 || (a_cnt == 2'd1 && a_rp == 1'(i))) pend_mask[a_wa_q[i]] = 1'b1;
      if (l_cnt == 2'd2 || (l_cnt == 2'd1 && l_rp == 1'(i))) pend_mask[l_wa_q[i]] = 1'b1;
    end
    if (rf_we) pend_mask[rf_wa] = 1'b1;
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, corner sequences and random run against a queue model
module tb_wb_arbiter;
  logic        clk, rst;
  logic        a_valid, l_valid, a_ready, l_ready, rf_we;
  logic [4:0]  a_wa, l_wa, rf_wa;
  logic [31:0] a_wd, l_wd, rf_wd, pend_mask;
  wb_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_wa(a_wa), .a_wd(a_wd), .a_ready(a_ready),
    .l_valid(l_valid), .l_wa(l_wa), .l_wd(l_wd), .l_ready(l_ready),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .pend_mask(pend_mask)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {logic [4:0] wa; logic [31:0] wd;} ent_t;
  typedef struct {
    bit rs;
    bit av; logic [4:0] aw; logic [31:0] ad;
    bit lv; logic [4:0] lw; logic [31:0] ld;
    bit we; logic [4:0] wa; logic [31:0] wd; logic [31:0] pm;
  } vec_t;
  ent_t        aq[$], lq[$];
  bit          m_last_l, m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  int          total = 0, bad = 0;
  vec_t        tv[13];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    foreach (aq[i]) m[aq[i].wa] = 1'b1;
    foreach (lq[i]) m[lq[i].wa] = 1'b1;
    if (m_we) m[m_wa] = 1'b1;
    return m;
  endfunction
  task automatic do_reset();
    a_valid = 0; l_valid = 0;
    rst = 1'b1;
    #1;
    chk("rst_we", rf_we, 0);
    chk("rst_wa", rf_wa, 0);
    chk("rst_wd", rf_wd, 0);
    chk("rst_mask", pend_mask, 0);
    chk("rst_a_ready", a_ready, 1);
    chk("rst_l_ready", l_ready, 1);
    aq.delete(); lq.delete();
    m_last_l = 1; m_we = 0; m_wa = 0; m_wd = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  // one clock: drive, check readiness, advance model at the edge
  task automatic step(input bit av, input logic [4:0] aw, input logic [31:0] ad,
                      input bit lv, input logic [4:0] lw, input logic [31:0] ld);
    int na, nl, pick;
    ent_t e;
    a_valid = av; a_wa = aw; a_wd = ad;
    l_valid = lv; l_wa = lw; l_wd = ld;
    na = aq.size(); nl = lq.size();
    chk("a_ready", a_ready, na < 2);
    chk("l_ready", l_ready, nl < 2);
    @(posedge clk);
    pick = 0;
    if (na > 0 && nl > 0) pick = m_last_l ? 1 : 2;
    else if (na > 0) pick = 1;
    else if (nl > 0) pick = 2;
    if (pick != 0) begin
      e = (pick == 1) ? aq.pop_front() : lq.pop_front();
      m_we = 1; m_wa = e.wa; m_wd = e.wd; m_last_l = (pick == 2);
    end else m_we = 0;
    if (av && na < 2 && aw != 0) aq.push_back('{aw, ad});
    if (lv && nl < 2 && lw != 0) lq.push_back('{lw, ld});
    #1;
    a_valid = 0; l_valid = 0;
  endtask
  task automatic cmp_model();
    chk("we", rf_we, m_we);
    chk("wa", rf_wa, m_wa);
    chk("wd", rf_wd, m_wd);
    chk("mask", pend_mask, model_mask());
  endtask
  initial begin
    rst = 0; a_valid = 0; l_valid = 0; a_wa = 0; l_wa = 0; a_wd = 0; l_wd = 0;
    tv[0]  = '{0, 1, 5, 32'hDEADBEEF, 0, 0, 0,     0, 5'd0, 32'h0,        32'h20};
    tv[1]  = '{0, 0, 0, 0,            0, 0, 0,     1, 5'd5, 32'hDEADBEEF, 32'h20};
    tv[2]  = '{0, 0, 0, 0,            0, 0, 0,     0, 5'd5, 32'hDEADBEEF, 32'h0};
    tv[3]  = '{1, 1, 1, 32'h11,       1, 2, 32'h22, 0, 5'd0, 32'h0,       32'h6};
    tv[4]  = '{0, 0, 0, 0,            0, 0, 0,     1, 5'd1, 32'h11,       32'h6};
    tv[5]  = '{0, 0, 0, 0,            0, 0, 0,     1, 5'd2, 32'h22,       32'h4};
    tv[6]  = '{0, 0, 0, 0,            0, 0, 0,     0, 5'd2, 32'h22,       32'h0};
    tv[7]  = '{0, 1, 0, 32'hFFFFFFFF, 0, 0, 0,     0, 5'd2, 32'h22,       32'h0};
    tv[8]  = '{0, 0, 0, 0,            0, 0, 0,     0, 5'd2, 32'h22,       32'h0};
    tv[9]  = '{0, 1, 7, 32'hA,        0, 0, 0,     0, 5'd2, 32'h22,       32'h80};
    tv[10] = '{0, 0, 0, 0,            1, 7, 32'hB, 1, 5'd7, 32'hA,        32'h80};
    tv[11] = '{0, 0, 0, 0,            0, 0, 0,     1, 5'd7, 32'hB,        32'h80};
    tv[12] = '{0, 0, 0, 0,            0, 0, 0,     0, 5'd7, 32'hB,        32'h0};
    #2;
    do_reset();
    foreach (tv[i]) begin
      if (tv[i].rs) do_reset();
      step(tv[i].av, tv[i].aw, tv[i].ad, tv[i].lv, tv[i].lw, tv[i].ld);
      chk($sformatf("vec%0d_we", i), rf_we, tv[i].we);
      chk($sformatf("vec%0d_wa", i), rf_wa, tv[i].wa);
      chk($sformatf("vec%0d_wd", i), rf_wd, tv[i].wd);
      chk($sformatf("vec%0d_mask", i), pend_mask, tv[i].pm);
    end
    // both sources saturated: alternation and backpressure
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1, 5'(i + 1), 32'h100 + i, 1, 5'(i + 16), 32'h200 + i);
      cmp_model();
    end
    // drain interrupted by an asynchronous reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 5'(i + 3), 32'h300 + i, 1, 5'(i + 20), 32'h400 + i);
      cmp_model();
    end
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("flushed_we", rf_we, 0);
      chk("flushed_mask", pend_mask, 0);
    end
    // random traffic
    do_reset();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      else begin
        step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)), $urandom);
        cmp_model();
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
